fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_skid_buf.sv | 73 +++++++
 rtl/fifo_reader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and the reader state encoding for the FIFO drain block.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned LEN_W          = 8;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer with valid/ready on both sides; head entry drives the output.
module fifo_skid_buf #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  input  logic [W-1:0] s_data_i,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign s_ready_o = (count_q != 2'd2);
  assign push      = s_valid_i && s_ready_o;
  assign pop       = (count_q != 2'd0) && m_ready_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = s_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_data_i;
        end else if (push) begin
          tail_d  = s_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // Full: no push is accepted, so a pop just promotes the tail.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = head_q;
  assign count_o   = count_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains len words from a FIFO into a two-entry output buffer, flagging the last word
// and pulsing done when it is accepted downstream.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_W-1:0]      words_read,
  output logic                  err_underflow
);

  if (FIFO_DEPTH == 0) begin : g_depth_chk
    $error("fifo_reader: FIFO_DEPTH must be nonzero");
  end

  rd_state_e          state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               infl_q, infl_last_q;

  logic [1:0]         buf_cnt;
  logic               buf_valid, buf_s_ready;
  logic [FIFO_WIDTH:0] buf_out;

  logic               pop_c, rd_c, last_hs_c;
  logic [2:0]         used_c;

  // Slots committed after this cycle: buffered + in flight - leaving now.
  assign pop_c     = buf_valid && m_ready;
  assign used_c    = 3'(buf_cnt) + 3'(infl_q) - 3'(pop_c);
  assign rd_c      = (state_q == READ) && !empty && (rem_q != '0)
                     && buf_s_ready && (used_c < 3'd2);
  assign last_hs_c = (state_q == FLUSH) && pop_c && buf_out[FIFO_WIDTH];

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    wr_cnt_d = wr_cnt_q;
    done_d   = 1'b0;
    err_d    = err_q | underflow;
    if (rd_c) begin
      rem_d    = rem_q - LEN_W'(1);
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = READ;
            rem_d   = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ:    if (rd_c && (rem_q == LEN_W'(1))) state_d = FLUSH;
      FLUSH:   if (last_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      wr_cnt_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      wr_cnt_q    <= wr_cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      infl_q      <= rd_c;
      infl_last_q <= rd_c && (rem_q == LEN_W'(1));
    end
  end

  fifo_skid_buf #(
    .W(FIFO_WIDTH + 1)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid_i(infl_q),
    .s_ready_o(buf_s_ready),
    .s_data_i ({infl_last_q, data_out}),
    .m_valid_o(buf_valid),
    .m_ready_i(m_ready),
    .m_data_o (buf_out),
    .count_o  (buf_cnt)
  );

  assign rd_en         = rd_c;
  assign busy          = (state_q != IDLE);
  assign done          = done_q | last_hs_c;
  assign m_valid       = buf_valid;
  assign m_data        = buf_out[FIFO_WIDTH-1:0];
  assign m_last        = buf_valid && buf_out[FIFO_WIDTH];
  assign words_read    = wr_cnt_q;
  assign err_underflow = err_q;

endmodule
